// File: rtl/nanop_pkg.sv
// Shared definitions for the nano-processor memory subsystem:
// responder states, the memory-mapped port address and the instruction opcodes.
package nanop_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [7:0] PORT_ADDR = 8'hFF;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_LDA = 8'h03;
    localparam logic [7:0] OP_STA = 8'h04;
    localparam logic [7:0] OP_JMP = 8'h05;
    localparam logic [7:0] OP_HLT = 8'h0F;

endpackage

// File: rtl/mem_responder_if.sv
// Bundle of the processor bus and loader signals around mem_responder.
interface mem_responder_if;

    logic [7:0] ADDR;
    logic [7:0] D;
    logic       WRITE;
    logic [7:0] Q;
    logic       cpu_reset_n;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       load_start;
    logic [7:0] LedBar;

    modport master (
        output ADDR, D, WRITE, load_valid, load_data, load_last, load_start,
        input  Q, cpu_reset_n, load_ready, LedBar
    );

    modport slave (
        input  ADDR, D, WRITE, load_valid, load_data, load_last, load_start,
        output Q, cpu_reset_n, load_ready, LedBar
    );

endinterface

// File: rtl/mem_responder_ram.sv
// 256x8 memory with one write and one read port, both clocked on the falling edge;
// a same-edge read of the written address returns the old contents.
module ram_dp (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [256];

    always_ff @(negedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mem_responder.sv
// Program memory responder: loads a program byte-stream while holding the processor,
// then serves processor reads/writes with a memory-mapped LED port at PORT_ADDR.
module mem_responder
    import nanop_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ADDR,
    input  logic [7:0] D,
    input  logic       WRITE,
    output logic [7:0] Q,
    output logic       cpu_reset_n,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    input  logic       load_start,
    output logic [7:0] LedBar
);

    state_t     state, state_next;
    logic [7:0] load_addr, load_addr_next;
    logic       accept;

    logic       pend_valid;
    logic [7:0] pend_addr, pend_data;

    logic       rst_q;
    logic       q_clear, q_from_port;
    logic [7:0] port_snap, ram_q;

    logic       port_hit;
    logic       ram_we;
    logic [7:0] ram_waddr, ram_wdata;

    assign load_ready  = (state == LOAD);
    assign cpu_reset_n = (state == RUN);
    assign accept      = load_valid & load_ready;
    assign port_hit    = (ADDR == PORT_ADDR);

    always_comb begin
        state_next     = state;
        load_addr_next = load_addr;
        case (state)
            LOAD: begin
                if (accept) begin
                    if (load_last || load_addr == 8'hFF) begin
                        state_next     = RUN;
                        load_addr_next = '0;
                    end else begin
                        load_addr_next = load_addr + 8'd1;
                    end
                end
            end
            RUN: begin
                if (load_start) begin
                    state_next     = LOAD;
                    load_addr_next = '0;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        rst_q <= reset;
        if (reset) begin
            state      <= LOAD;
            load_addr  <= '0;
            pend_valid <= 1'b0;
        end else begin
            state      <= state_next;
            load_addr  <= load_addr_next;
            // Pending lives exactly one cycle: it is consumed by the falling edge in between.
            pend_valid <= accept;
            if (accept) begin
                pend_addr <= load_addr;
                pend_data <= load_data;
            end
        end
    end

    // The last loader byte lands on the first falling edge of RUN, ahead of any fetch.
    assign ram_we    = pend_valid | ((state == RUN) & WRITE & ~port_hit);
    assign ram_waddr = pend_valid ? pend_addr : ADDR;
    assign ram_wdata = pend_valid ? pend_data : D;

    ram_dp u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ADDR),
        .rdata (ram_q)
    );

    // Reset is taken at the rising edge; the falling-edge registers follow half a cycle later.
    always_ff @(negedge clk) begin
        q_clear     <= rst_q;
        q_from_port <= port_hit;
        port_snap   <= LedBar;
        if (rst_q) begin
            LedBar <= '0;
        end else if (state == RUN && WRITE && port_hit) begin
            LedBar <= D;
        end
    end

    assign Q = q_clear ? '0 : (q_from_port ? port_snap : ram_q);

endmodule

// File: tb/tb_mem_responder.sv
// Directed + randomized bench for mem_responder against a cycle-level behavioural model.
module tb_mem_responder;
    import nanop_pkg::*;

    logic clk = 1'b0;
    logic reset;

    mem_responder_if bus ();

    mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .ADDR        (bus.ADDR),
        .D           (bus.D),
        .WRITE       (bus.WRITE),
        .Q           (bus.Q),
        .cpu_reset_n (bus.cpu_reset_n),
        .load_valid  (bus.load_valid),
        .load_data   (bus.load_data),
        .load_last   (bus.load_last),
        .load_ready  (bus.load_ready),
        .load_start  (bus.load_start),
        .LedBar      (bus.LedBar)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Behavioural model state
    bit         m_run   = 1'b0;
    int         m_addr  = 0;
    bit         m_pend  = 1'b0;
    logic [7:0] m_paddr = '0;
    logic [7:0] m_pdata = '0;
    bit         m_rstq  = 1'b1;
    logic [7:0] m_mem [256];
    bit         m_known [256];
    logic [7:0] m_led   = '0;
    logic [7:0] m_q     = '0;
    bit         m_qk    = 1'b0;
    int         accepted = 0;

    logic [7:0] prog [8];

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
    endtask

    // One clock: model the falling-edge memory/port activity, then the rising-edge
    // loader/state behaviour, then compare every observable output.
    task automatic cycle();
        @(negedge clk);
        if (m_rstq) begin
            m_q   = '0;
            m_qk  = 1'b1;
            m_led = '0;
        end else begin
            if (bus.ADDR == PORT_ADDR) begin
                m_q  = m_led;
                m_qk = 1'b1;
            end else begin
                m_q  = m_mem[bus.ADDR];
                m_qk = m_known[bus.ADDR];
            end
            if (m_run && bus.WRITE && bus.ADDR == PORT_ADDR) m_led = bus.D;
        end
        if (m_pend) begin
            m_mem[m_paddr]   = m_pdata;
            m_known[m_paddr] = 1'b1;
        end else if (!m_rstq && m_run && bus.WRITE && bus.ADDR != PORT_ADDR) begin
            m_mem[bus.ADDR]   = bus.D;
            m_known[bus.ADDR] = 1'b1;
        end
        m_pend = 1'b0;

        @(posedge clk);
        m_rstq = reset;
        if (reset) begin
            m_run  = 1'b0;
            m_addr = 0;
            m_pend = 1'b0;
        end else if (!m_run) begin
            if (bus.load_valid) begin
                accepted++;
                m_pend  = 1'b1;
                m_paddr = 8'(m_addr);
                m_pdata = bus.load_data;
                if (bus.load_last || m_addr == 255) begin
                    m_run  = 1'b1;
                    m_addr = 0;
                end else begin
                    m_addr++;
                end
            end
        end else if (bus.load_start) begin
            m_run  = 1'b0;
            m_addr = 0;
        end
        #1;
        chk8("load_ready",  {7'b0, bus.load_ready},  {7'b0, !m_run});
        chk8("cpu_reset_n", {7'b0, bus.cpu_reset_n}, {7'b0, m_run});
        chk8("LedBar", bus.LedBar, m_led);
        chk8("load_addr", dut.load_addr, 8'(m_addr));
        if (m_qk) chk8("Q", bus.Q, m_q);
    endtask

    task automatic check_ram();
        for (int i = 0; i < 256; i++) begin
            if (m_known[i]) chk8("ram_contents", dut.u_ram.mem[i], m_mem[i]);
        end
    endtask

    task automatic run_traffic(input int n, input int unsigned span);
        for (int k = 0; k < n; k++) begin
            bus.ADDR  = ($urandom_range(0, 7) == 0) ? PORT_ADDR : 8'($urandom_range(0, span));
            bus.WRITE = 1'($urandom_range(0, 1));
            bus.D     = 8'($urandom);
            cycle();
        end
        bus.WRITE = 1'b0;
    endtask

    initial begin
        int acc0;
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
        prog[0] = OP_ADD; prog[1] = 8'd3;  prog[2] = 8'd4; prog[3] = 8'd0;
        prog[4] = OP_SUB; prog[5] = 8'd12; prog[6] = 8'd8; prog[7] = 8'd0;

        reset = 1'b1;
        bus.ADDR = '0; bus.D = '0; bus.WRITE = 1'b0;
        bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0; bus.load_start = 1'b0;
        repeat (2) cycle();
        chk8("reset_Q", bus.Q, 8'h00);
        chk8("reset_ready", {7'b0, bus.load_ready}, 8'h01);
        reset = 1'b0;

        // Eight program bytes with a gap after the third
        for (int i = 0; i < 8; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = prog[i];
            bus.load_last  = (i == 7);
            cycle();
            if (i == 2) begin
                acc0 = accepted;
                bus.load_valid = 1'b0;
                bus.load_data  = 8'hEE;
                cycle();
                chk8("gap_no_accept", 8'(accepted - acc0), 8'h00);
                chk8("gap_addr_hold", dut.load_addr, 8'h03);
            end
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        chk8("run_after_last", {7'b0, bus.cpu_reset_n}, 8'h01);

        for (int i = 0; i < 8; i++) begin
            bus.ADDR = 8'(i);
            cycle();
            chk8("prog_read", bus.Q, prog[i]);
        end

        // Read-before-write at a RAM address
        bus.ADDR = 8'h03; bus.D = 8'd7; bus.WRITE = 1'b1;
        cycle();
        chk8("rbw_old", bus.Q, 8'h00);
        bus.WRITE = 1'b0;
        cycle();
        chk8("rbw_new", bus.Q, 8'd7);

        // LED port write and readback
        bus.ADDR = PORT_ADDR; bus.D = 8'hA5; bus.WRITE = 1'b1;
        cycle();
        chk8("led_write", bus.LedBar, 8'hA5);
        chk8("led_q_old", bus.Q, 8'h00);
        bus.WRITE = 1'b0;
        cycle();
        chk8("led_read", bus.Q, 8'hA5);

        run_traffic(150, 15);

        // Reload request with a simultaneous loader byte: the byte is not taken
        acc0 = accepted;
        bus.load_start = 1'b1; bus.load_valid = 1'b1; bus.load_data = 8'h55; bus.load_last = 1'b1;
        cycle();
        chk8("reload_held", {7'b0, bus.cpu_reset_n}, 8'h00);
        chk8("reload_no_accept", 8'(accepted - acc0), 8'h00);
        bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_last = 1'b0;
        cycle();
        check_ram();

        // Full 256-byte load with random gaps and ignored bus writes, no load_last
        acc0 = accepted;
        for (int k = 0; k < 1200 && (accepted - acc0) < 256; k++) begin
            bus.load_valid = ($urandom_range(0, 5) != 0);
            bus.load_data  = 8'($urandom);
            bus.ADDR       = 8'($urandom);
            bus.WRITE      = 1'($urandom_range(0, 1));
            bus.D          = 8'($urandom);
            cycle();
        end
        bus.load_valid = 1'b0;
        bus.WRITE      = 1'b0;
        chk8("wrap_count", 8'(accepted - acc0), 8'h00);
        chk8("wrap_run", {7'b0, bus.cpu_reset_n}, 8'h01);
        chk8("wrap_addr", dut.load_addr, 8'h00);
        cycle();
        check_ram();

        // Port writes never reach RAM[255]
        bus.ADDR = PORT_ADDR; bus.D = 8'h3C; bus.WRITE = 1'b1;
        cycle();
        bus.WRITE = 1'b0;
        cycle();
        chk8("ram255_kept", dut.u_ram.mem[255], m_mem[255]);
        chk8("led_3c", bus.LedBar, 8'h3C);

        run_traffic(120, 255);

        // Reset after three accepted bytes of a reload
        bus.load_start = 1'b1;
        cycle();
        bus.load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 8'($urandom);
            cycle();
        end
        bus.load_valid = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        chk8("reset_mid_addr", dut.load_addr, 8'h00);
        chk8("reset_mid_led", bus.LedBar, 8'h00);
        check_ram();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
